// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory between IF fetch and the program loader, sequencing boot/drain/run
module imem_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int LD_MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              boot_done_i,
  input  logic              boot_req_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [31:0]       ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_stall_o,
  output logic [1:0]        state_o
);
  typedef enum logic [1:0] {BOOT = 2'd0, DRAIN = 2'd1, RUN = 2'd2} state_t;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);
  localparam int CW = $clog2(LD_MAX_BURST + 1);
  localparam logic [CW-1:0] MAX = CW'(LD_MAX_BURST);
  state_t state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic ld_win, if_ok, ld_ok;
  logic rd_if, rd_ld, rd_nop;
  logic [DATA_W-1:0] if_hold, ld_hold;
  assign if_ok = if_addr_i[31:ADDR_W+2] == '0;
  assign ld_ok = ld_addr_i[31:ADDR_W+2] == '0;
  // Out-of-range accesses are granted but never reach the memory
  assign mem_en_o    = if_gnt_o ? if_ok : ld_gnt_o & ld_ok;
  assign mem_we_o    = ld_gnt_o & ld_we_i & ld_ok;
  assign mem_addr_o  = if_gnt_o ? if_addr_i[ADDR_W+1:2] : ld_addr_i[ADDR_W+1:2];
  assign mem_wdata_o = ld_wdata_i;
  // Read data comes straight from memory in the response cycle, otherwise the last response is held
  assign if_rvalid_o = rd_if;
  assign ld_rvalid_o = rd_ld;
  assign if_rdata_o  = rd_if ? (rd_nop ? NOP : mem_rdata_i) : if_hold;
  assign ld_rdata_o  = rd_ld ? (rd_nop ? NOP : mem_rdata_i) : ld_hold;
  assign state_o     = state;
  // Grant arbitration, stall and next-state; grants are forced low while reset is held
  always_comb begin
    state_nxt   = state;
    burst_nxt   = '0;
    ld_win      = 1'b0;
    ld_gnt_o    = 1'b0;
    if_gnt_o    = 1'b0;
    cpu_stall_o = 1'b1;
    case (state)
      BOOT: begin
        ld_gnt_o  = ld_req_i & reset_i;
        state_nxt = boot_done_i ? DRAIN : BOOT;
      end
      DRAIN: state_nxt = RUN;
      RUN: begin
        ld_win      = ld_req_i & (burst_cnt < MAX || !if_req_i);
        ld_gnt_o    = ld_win & reset_i;
        if_gnt_o    = if_req_i & ~ld_win & reset_i;
        cpu_stall_o = if_req_i & ~if_gnt_o;
        burst_nxt   = (if_gnt_o || !ld_req_i) ? '0 :
                      (ld_gnt_o && if_req_i && burst_cnt < MAX) ? burst_cnt + 1'b1 : burst_cnt;
        state_nxt   = boot_req_i ? BOOT : RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end
  // State, burst counter and in-flight read tracking
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= BOOT;
      burst_cnt <= '0;
      rd_if     <= 1'b0;
      rd_ld     <= 1'b0;
      rd_nop    <= 1'b0;
      if_hold   <= '0;
      ld_hold   <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      rd_if     <= if_gnt_o;
      rd_ld     <= ld_gnt_o & ~ld_we_i;
      rd_nop    <= if_gnt_o ? ~if_ok : ~ld_ok;
      if (rd_if) if_hold <= if_rdata_o;
      if (rd_ld) ld_hold <= ld_rdata_o;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of boot sequencing, arbitration, out-of-range handling and async reset
module tb_imem_arbiter;
  logic        clk = 0, reset_i = 0, boot_done_i = 0, boot_req_i = 0;
  logic        if_req_i = 0, ld_req_i = 0, ld_we_i = 0;
  logic [31:0] if_addr_i = 0, ld_addr_i = 0, ld_wdata_i = 0;
  logic        if_gnt_o, if_rvalid_o, ld_gnt_o, ld_rvalid_o, mem_en_o, mem_we_o, cpu_stall_o;
  logic [31:0] if_rdata_o, ld_rdata_o, mem_wdata_o, mem_rdata_i = 0;
  logic [4:0]  mem_addr_o;
  logic [1:0]  state_o;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;

  imem_arbiter dut (
    .clk_i(clk), .reset_i(reset_i), .boot_done_i(boot_done_i), .boot_req_i(boot_req_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o), .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .cpu_stall_o(cpu_stall_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port memory seen by the arbiter
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_addr_o];
    end
  end

  task automatic test_reset();
    #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall got %b exp 1", cpu_stall_o); end
    checks++; if ({if_gnt_o, ld_gnt_o, if_rvalid_o, ld_rvalid_o, mem_en_o, mem_we_o} !== 6'b0) begin errors++; $display("FAIL reset_ctl got %b exp 000000", {if_gnt_o, ld_gnt_o, if_rvalid_o, ld_rvalid_o, mem_en_o, mem_we_o}); end
    checks++; if ({if_rdata_o, ld_rdata_o} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata_o, ld_rdata_o}); end
    @(negedge clk); reset_i = 1;
  endtask

  task automatic test_boot();
    @(negedge clk); ld_req_i = 1; ld_we_i = 1; ld_addr_i = 32'h0; ld_wdata_i = 32'hAAAA0001; if_req_i = 1; if_addr_i = 32'h4; #1;
    checks++; if ({ld_gnt_o, if_gnt_o, mem_en_o, mem_we_o} !== 4'b1011) begin errors++; $display("FAIL boot_wr0 got %b exp 1011", {ld_gnt_o, if_gnt_o, mem_en_o, mem_we_o}); end
    @(negedge clk); ld_addr_i = 32'h4; ld_wdata_i = 32'hAAAA0002; #1;
    checks++; if ({ld_gnt_o, if_gnt_o, mem_addr_o} !== {2'b10, 5'd1}) begin errors++; $display("FAIL boot_wr1 got %b exp 1000001", {ld_gnt_o, if_gnt_o, mem_addr_o}); end
    @(negedge clk); ld_req_i = 0; ld_we_i = 0; boot_done_i = 1; #1;
    checks++; if ({state_o, if_gnt_o, cpu_stall_o} !== 4'b0001) begin errors++; $display("FAIL boot_done got %b exp 0001", {state_o, if_gnt_o, cpu_stall_o}); end
    @(negedge clk); boot_done_i = 0; #1;
    checks++; if ({state_o, if_gnt_o, ld_gnt_o, cpu_stall_o} !== 5'b01001) begin errors++; $display("FAIL drain got %b exp 01001", {state_o, if_gnt_o, ld_gnt_o, cpu_stall_o}); end
    @(negedge clk); #1;
    checks++; if ({state_o, if_gnt_o, cpu_stall_o, mem_addr_o} !== {4'b1010, 5'd1}) begin errors++; $display("FAIL run_fetch got %b exp 101000001", {state_o, if_gnt_o, cpu_stall_o, mem_addr_o}); end
    @(negedge clk); if_req_i = 0; #1;
    checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'hAAAA0002}) begin errors++; $display("FAIL fetch_data got %b/%h exp 1/aaaa0002", if_rvalid_o, if_rdata_o); end
  endtask

  task automatic test_burst();
    logic [7:0] pat = 8'b1110_1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if_req_i = 1; if_addr_i = 32'h0; ld_req_i = 1; ld_we_i = 0; ld_addr_i = 32'h4; #1;
      checks++; if ({ld_gnt_o, if_gnt_o, cpu_stall_o} !== {pat[i], !pat[i], pat[i]}) begin errors++; $display("FAIL burst[%0d] got %b exp %b", i, {ld_gnt_o, if_gnt_o, cpu_stall_o}, {pat[i], !pat[i], pat[i]}); end
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk); ld_req_i = 0; if_req_i = 1; if_addr_i = 32'h80; #1;
    checks++; if ({if_gnt_o, mem_en_o} !== 2'b10) begin errors++; $display("FAIL oor_fetch got %b exp 10", {if_gnt_o, mem_en_o}); end
    @(negedge clk); if_req_i = 0; ld_req_i = 1; ld_we_i = 1; ld_addr_i = 32'h80; ld_wdata_i = 32'hDEADBEEF; #1;
    checks++; if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h13}) begin errors++; $display("FAIL oor_nop got %b/%h exp 1/00000013", if_rvalid_o, if_rdata_o); end
    checks++; if ({ld_gnt_o, mem_en_o, mem_we_o} !== 3'b100) begin errors++; $display("FAIL oor_write got %b exp 100", {ld_gnt_o, mem_en_o, mem_we_o}); end
    @(negedge clk); ld_req_i = 0; ld_we_i = 0; #1;
    checks++; if ({ld_rvalid_o, if_rvalid_o, if_rdata_o} !== {2'b00, 32'h13}) begin errors++; $display("FAIL oor_hold got %b/%h exp 00/00000013", {ld_rvalid_o, if_rvalid_o}, if_rdata_o); end
  endtask

  task automatic test_reload();
    @(negedge clk); ld_req_i = 1; ld_we_i = 0; ld_addr_i = 32'h0; boot_req_i = 1; #1;
    checks++; if ({ld_gnt_o, state_o} !== 3'b110) begin errors++; $display("FAIL reload_gnt got %b exp 110", {ld_gnt_o, state_o}); end
    @(negedge clk); ld_req_i = 0; boot_req_i = 0; if_req_i = 1; if_addr_i = 32'h0; #1;
    checks++; if ({ld_rvalid_o, ld_rdata_o} !== {1'b1, 32'hAAAA0001}) begin errors++; $display("FAIL reload_data got %b/%h exp 1/aaaa0001", ld_rvalid_o, ld_rdata_o); end
    checks++; if ({state_o, cpu_stall_o, if_gnt_o} !== 4'b0010) begin errors++; $display("FAIL reload_state got %b exp 0010", {state_o, cpu_stall_o, if_gnt_o}); end
  endtask

  task automatic test_boot_done_write();
    @(negedge clk); if_req_i = 0; ld_req_i = 1; ld_we_i = 1; ld_addr_i = 32'h8; ld_wdata_i = 32'hBBBB0003; boot_done_i = 1; #1;
    checks++; if ({ld_gnt_o, mem_en_o, mem_we_o, mem_addr_o} !== {3'b111, 5'd2}) begin errors++; $display("FAIL bd_write got %b exp 11100010", {ld_gnt_o, mem_en_o, mem_we_o, mem_addr_o}); end
    @(negedge clk); ld_req_i = 0; ld_we_i = 0; boot_done_i = 0; #1;
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL bd_drain got %0d exp 1", state_o); end
    @(negedge clk); if_req_i = 1; if_addr_i = 32'h8; #1;
    checks++; if ({state_o, if_gnt_o} !== 3'b101) begin errors++; $display("FAIL bd_run got %b exp 101", {state_o, if_gnt_o}); end
    @(negedge clk); if_req_i = 0; #1;
    checks++; if (if_rdata_o !== 32'hBBBB0003) begin errors++; $display("FAIL bd_readback got %h exp bbbb0003", if_rdata_o); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); if_req_i = 1; if_addr_i = 32'h4; #1;
    checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL ar_gnt got %b exp 1", if_gnt_o); end
    @(posedge clk); #2; reset_i = 0; #1;
    checks++; if ({if_gnt_o, if_rvalid_o, mem_en_o, cpu_stall_o, state_o} !== 6'b000100) begin errors++; $display("FAIL ar_outputs got %b exp 000100", {if_gnt_o, if_rvalid_o, mem_en_o, cpu_stall_o, state_o}); end
    checks++; if (if_rdata_o !== 32'h0) begin errors++; $display("FAIL ar_rdata got %h exp 0", if_rdata_o); end
    @(negedge clk); reset_i = 1; if_req_i = 0;
    @(negedge clk); #1;
    checks++; if ({if_rvalid_o, state_o} !== 3'b000) begin errors++; $display("FAIL ar_release got %b exp 000", {if_rvalid_o, state_o}); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_boot();
    test_burst();
    test_out_of_range();
    test_reload();
    test_boot_done_write();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
